// File: rtl/fifo_byte_unpacker.sv
// fifo_byte_unpacker: pops 32-bit words from the sample FIFO and streams an
// optional header byte plus the low BYTES_OUT bytes (MSB first) on an 8-bit
// valid/ready interface. One word in flight at a time.
module fifo_byte_unpacker #(
  parameter int           DATA_W    = 32,
  parameter int           BYTES_OUT = 2,
  parameter bit           HDR_EN    = 1'b1,
  parameter logic [7:0]   HDR_BYTE  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic [15:0]       word_cnt
);

  // Byte positions per word, header included when enabled.
  localparam int NB    = BYTES_OUT + (HDR_EN ? 1 : 0);
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_LATCH, S_SEND} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_rd_en, w_rd_en_nxt;
  logic                r_tx_valid, w_tx_valid_nxt;
  logic [7:0]          r_tx_data, w_tx_data_nxt;
  logic [15:0]         r_word_cnt, w_word_cnt_nxt;
  logic [DATA_W-1:0]   r_word_q, w_word_q_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic                w_accept;
  logic                w_last;

  // Byte at position p of a word: position 0 is the header when enabled,
  // the remaining positions walk the low BYTES_OUT bytes from the top down.
  function automatic logic [7:0] f_byte(input logic [DATA_W-1:0] w,
                                        input logic [IDX_W-1:0]  p);
    int                k;
    logic [DATA_W-1:0] sh;
    if (HDR_EN && (p == '0)) return HDR_BYTE;
    k  = int'(p) - (HDR_EN ? 1 : 0);
    sh = w >> (8 * (BYTES_OUT - 1 - k));
    return sh[7:0];
  endfunction

  assign w_accept = r_tx_valid && tx_ready;
  assign w_last   = (r_idx == IDX_W'(NB - 1));

  // State and datapath registers; synchronous reset drops any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rd_en    <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_word_cnt <= 16'h0000;
      r_word_q   <= '0;
      r_idx      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_en    <= w_rd_en_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_word_q   <= w_word_q_nxt;
      r_idx      <= w_idx_nxt;
    end
  end

  // Next-state and next-register values; everything holds unless a state
  // acts on it, which also gives the hold-under-backpressure behaviour.
  always_comb begin
    w_state_nxt    = r_state;
    w_rd_en_nxt    = 1'b0;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_data_nxt  = r_tx_data;
    w_word_cnt_nxt = r_word_cnt;
    w_word_q_nxt   = r_word_q;
    w_idx_nxt      = r_idx;
    case (r_state)
      S_IDLE: begin
        if (!fifo_empty) begin
          w_state_nxt = S_RD;
          w_rd_en_nxt = 1'b1;
        end
      end
      S_RD: begin
        // FIFO read data appears the cycle after the pop.
        w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        w_word_q_nxt   = fifo_dout;
        w_tx_valid_nxt = 1'b1;
        w_tx_data_nxt  = f_byte(fifo_dout, '0);
        w_idx_nxt      = '0;
        w_state_nxt    = S_SEND;
      end
      S_SEND: begin
        if (w_accept) begin
          if (w_last) begin
            w_word_cnt_nxt = r_word_cnt + 16'd1;
            w_tx_valid_nxt = 1'b0;
            // Chain straight into the next pop when data is waiting.
            if (!fifo_empty) begin
              w_state_nxt = S_RD;
              w_rd_en_nxt = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_idx_nxt     = r_idx + 1'b1;
            w_tx_data_nxt = f_byte(r_word_q, r_idx + 1'b1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign fifo_rd_en = r_rd_en;
  assign tx_valid   = r_tx_valid;
  assign tx_data    = r_tx_data;
  assign word_cnt   = r_word_cnt;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fifo_byte_unpacker.sv
// Directed bench: dut0 uses defaults (header on), dut1 has the header off.
// Each DUT is fed by a small FIFO model with one-cycle registered read data.
module tb_fifo_byte_unpacker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut0 side
  logic [31:0] mem0 [0:15];
  logic [7:0]  wp0 = 8'd0, rp0 = 8'd0;
  logic [31:0] d0 = 32'h0;
  logic        fe0, rd0, rdy0, v0, b0;
  logic [7:0]  td0;
  logic [15:0] c0;
  int          nrd0 = 0;

  // dut1 side
  logic [31:0] mem1 [0:15];
  logic [7:0]  wp1 = 8'd0, rp1 = 8'd0;
  logic [31:0] d1 = 32'h0;
  logic        fe1, rd1, rdy1, v1, b1;
  logic [7:0]  td1;
  logic [15:0] c1;
  int          nrd1 = 0;

  int n_chk  = 0;
  int n_pass = 0;

  assign fe0 = (wp0 == rp0);
  assign fe1 = (wp1 == rp1);

  fifo_byte_unpacker dut0 (
    .clk(clk), .rst(rst), .fifo_empty(fe0), .fifo_dout(d0), .fifo_rd_en(rd0),
    .tx_ready(rdy0), .tx_valid(v0), .tx_data(td0), .busy(b0), .word_cnt(c0)
  );

  fifo_byte_unpacker #(.HDR_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .fifo_empty(fe1), .fifo_dout(d1), .fifo_rd_en(rd1),
    .tx_ready(rdy1), .tx_valid(v1), .tx_data(td1), .busy(b1), .word_cnt(c1)
  );

  // FIFO models: pop on rd_en, data registered for the next cycle
  always @(posedge clk) begin
    if (rd0) begin
      d0   <= mem0[rp0[3:0]];
      rp0  <= rp0 + 8'd1;
      nrd0 <= nrd0 + 1;
    end
    if (rd1) begin
      d1   <= mem1[rp1[3:0]];
      rp1  <= rp1 + 8'd1;
      nrd1 <= nrd1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h exp %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic push0(input logic [31:0] w);
    mem0[wp0[3:0]] = w;
    wp0 = wp0 + 8'd1;
  endtask

  task automatic push1(input logic [31:0] w);
    mem1[wp1[3:0]] = w;
    wp1 = wp1 + 8'd1;
  endtask

  // Advance to the next falling edge and check one DUT's outputs.
  // Data is only compared while valid is expected high.
  task automatic ex(input int u, input string tag, input logic rd, input logic v,
                    input logic [7:0] d, input logic b, input logic [15:0] c);
    logic ord, ov, ob;
    logic [7:0] od;
    logic [15:0] oc;
    @(negedge clk);
    ord = (u == 0) ? rd0 : rd1;
    ov  = (u == 0) ? v0  : v1;
    od  = (u == 0) ? td0 : td1;
    ob  = (u == 0) ? b0  : b1;
    oc  = (u == 0) ? c0  : c1;
    chk($sformatf("%s.rd_en", tag), {31'd0, ord}, {31'd0, rd});
    chk($sformatf("%s.valid", tag), {31'd0, ov}, {31'd0, v});
    if (v) chk($sformatf("%s.data", tag), {24'd0, od}, {24'd0, d});
    chk($sformatf("%s.busy", tag), {31'd0, ob}, {31'd0, b});
    chk($sformatf("%s.cnt", tag), {16'd0, oc}, {16'd0, c});
  endtask

  initial begin
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    rst  = 1'b1;
    push0(32'h1234ABCD);

    // Reset held two cycles with data waiting: everything stays quiet.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst.rd_en", {31'd0, rd0}, 32'd0);
      chk("rst.valid", {31'd0, v0}, 32'd0);
      chk("rst.data",  {24'd0, td0}, 32'd0);
      chk("rst.busy",  {31'd0, b0}, 32'd0);
      chk("rst.cnt",   {16'd0, c0}, 32'd0);
    end
    rst = 1'b0;

    // Single word, header on: A5 AB CD back to back
    ex(0, "a1", 1, 0, 8'h00, 1, 16'd0);
    ex(0, "a2", 0, 0, 8'h00, 1, 16'd0);
    ex(0, "a3", 0, 1, 8'hA5, 1, 16'd0);
    ex(0, "a4", 0, 1, 8'hAB, 1, 16'd0);
    ex(0, "a5", 0, 1, 8'hCD, 1, 16'd0);
    ex(0, "a6", 0, 0, 8'h00, 0, 16'd1);
    chk("a.pulses", nrd0, 32'd1);

    // Backpressure: AB held for five cycles
    push0(32'h1234ABCD);
    ex(0, "b1", 1, 0, 8'h00, 1, 16'd1);
    ex(0, "b2", 0, 0, 8'h00, 1, 16'd1);
    ex(0, "b3", 0, 1, 8'hA5, 1, 16'd1);
    ex(0, "b4", 0, 1, 8'hAB, 1, 16'd1);
    rdy0 = 1'b0;
    for (int i = 0; i < 5; i++) ex(0, "bhold", 0, 1, 8'hAB, 1, 16'd1);
    rdy0 = 1'b1;
    ex(0, "b5", 0, 1, 8'hCD, 1, 16'd1);
    ex(0, "b6", 0, 0, 8'h00, 0, 16'd2);
    chk("b.pulses", nrd0, 32'd2);

    // Reset after the header is accepted drops the rest of the word
    push0(32'hDEADBEEF);
    ex(0, "c1", 1, 0, 8'h00, 1, 16'd2);
    ex(0, "c2", 0, 0, 8'h00, 1, 16'd2);
    ex(0, "c3", 0, 1, 8'hA5, 1, 16'd2);
    ex(0, "c4", 0, 1, 8'hBE, 1, 16'd2);
    rst = 1'b1;
    ex(0, "c5", 0, 0, 8'h00, 0, 16'd0);
    chk("c5.data", {24'd0, td0}, 32'd0);
    rst = 1'b0;
    push0(32'h0000C3D4);
    ex(0, "d1", 1, 0, 8'h00, 1, 16'd0);
    ex(0, "d2", 0, 0, 8'h00, 1, 16'd0);
    ex(0, "d3", 0, 1, 8'hA5, 1, 16'd0);
    ex(0, "d4", 0, 1, 8'hC3, 1, 16'd0);
    ex(0, "d5", 0, 1, 8'hD4, 1, 16'd0);
    ex(0, "d6", 0, 0, 8'h00, 0, 16'd1);

    // Counter wrap: preset to FFFF, one more word wraps to 0
    force dut0.r_word_cnt = 16'hFFFF;
    @(negedge clk);
    release dut0.r_word_cnt;
    ex(0, "w0", 0, 0, 8'h00, 0, 16'hFFFF);
    push0(32'h00005A5A);
    ex(0, "w1", 1, 0, 8'h00, 1, 16'hFFFF);
    ex(0, "w2", 0, 0, 8'h00, 1, 16'hFFFF);
    ex(0, "w3", 0, 1, 8'hA5, 1, 16'hFFFF);
    ex(0, "w4", 0, 1, 8'h5A, 1, 16'hFFFF);
    ex(0, "w5", 0, 1, 8'h5A, 1, 16'hFFFF);
    ex(0, "w6", 0, 0, 8'h00, 0, 16'h0000);
    chk("w.pulses", nrd0, 32'd5);

    // Back-to-back, header off: 11 11 22 22, second pop right after last 11
    push1(32'h00001111);
    push1(32'h00002222);
    ex(1, "m1", 1, 0, 8'h00, 1, 16'd0);
    ex(1, "m2", 0, 0, 8'h00, 1, 16'd0);
    ex(1, "m3", 0, 1, 8'h11, 1, 16'd0);
    ex(1, "m4", 0, 1, 8'h11, 1, 16'd0);
    ex(1, "m5", 1, 0, 8'h00, 1, 16'd1);
    ex(1, "m6", 0, 0, 8'h00, 1, 16'd1);
    ex(1, "m7", 0, 1, 8'h22, 1, 16'd1);
    ex(1, "m8", 0, 1, 8'h22, 1, 16'd1);
    ex(1, "m9", 0, 0, 8'h00, 0, 16'd2);
    chk("m.pulses", nrd1, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
